// File: rtl/rf_wr_arb_if.sv
// Write-request bus between the two writeback requesters and the register-file arbiter.
interface rf_wr_arb_if;
    logic        stall;
    logic        a_req;
    logic        b_req;
    logic [2:0]  a_regsel;
    logic [2:0]  b_regsel;
    logic [15:0] a_data;
    logic [15:0] b_data;
    logic        a_gnt;
    logic        b_gnt;
    logic        write;
    logic [2:0]  writeregsel;
    logic [15:0] writedata;
    logic [7:0]  pend;
    logic [7:0]  conflict_cnt;

    modport slave (
        input  stall, a_req, b_req, a_regsel, b_regsel, a_data, b_data,
        output a_gnt, b_gnt, write, writeregsel, writedata, pend, conflict_cnt
    );

    modport master (
        output stall, a_req, b_req, a_regsel, b_regsel, a_data, b_data,
        input  a_gnt, b_gnt, write, writeregsel, writedata, pend, conflict_cnt
    );
endinterface

// File: rtl/rf_wr_arb.sv
// Two-requester register-file write arbiter: combinational grant, registered write port,
// pending-destination tracking and a saturating contention counter.
module rf_wr_arb #(
    parameter bit RR_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    rf_wr_arb_if.slave   bus
);
    logic        r_lg;
    logic        r_write;
    logic [2:0]  r_writeregsel;
    logic [15:0] r_writedata;
    logic [7:0]  r_pend;
    logic [7:0]  r_conflict_cnt;

    logic        w_a_wins_tie;
    logic        w_a_gnt;
    logic        w_b_gnt;
    logic        w_any_gnt;
    logic [7:0]  w_pend_nxt;

    // A takes a tie under fixed priority, or under round-robin when B was last served.
    assign w_a_wins_tie = !RR_EN || r_lg;

    assign w_a_gnt   = rst && !bus.stall && bus.a_req && (!bus.b_req || w_a_wins_tie);
    assign w_b_gnt   = rst && !bus.stall && bus.b_req && (!bus.a_req || !w_a_wins_tie);
    assign w_any_gnt = w_a_gnt || w_b_gnt;

    always_comb begin
        w_pend_nxt = 8'h00;
        if (bus.a_req && !w_a_gnt)
            w_pend_nxt = w_pend_nxt | (8'h01 << bus.a_regsel);
        if (bus.b_req && !w_b_gnt)
            w_pend_nxt = w_pend_nxt | (8'h01 << bus.b_regsel);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lg           <= 1'b1;
            r_write        <= 1'b0;
            r_writeregsel  <= 3'd0;
            r_writedata    <= 16'h0000;
            r_pend         <= 8'h00;
            r_conflict_cnt <= 8'h00;
        end else begin
            r_write <= w_any_gnt;
            r_pend  <= w_pend_nxt;
            if (w_a_gnt) begin
                r_lg          <= 1'b0;
                r_writeregsel <= bus.a_regsel;
                r_writedata   <= bus.a_data;
            end else if (w_b_gnt) begin
                r_lg          <= 1'b1;
                r_writeregsel <= bus.b_regsel;
                r_writedata   <= bus.b_data;
            end
            if (bus.a_req && bus.b_req && (r_conflict_cnt != 8'hFF))
                r_conflict_cnt <= r_conflict_cnt + 8'h01;
        end
    end

    assign bus.a_gnt        = w_a_gnt;
    assign bus.b_gnt        = w_b_gnt;
    assign bus.write        = r_write;
    assign bus.writeregsel  = r_writeregsel;
    assign bus.writedata    = r_writedata;
    assign bus.pend         = r_pend;
    assign bus.conflict_cnt = r_conflict_cnt;
endmodule

// File: tb/tb_rf_wr_arb.sv
// Directed bench for rf_wr_arb: a round-robin instance and a fixed-priority instance
// share the same stimulus.
module tb_rf_wr_arb;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    rf_wr_arb_if if_rr ();
    rf_wr_arb_if if_fp ();

    assign if_fp.stall    = if_rr.stall;
    assign if_fp.a_req    = if_rr.a_req;
    assign if_fp.b_req    = if_rr.b_req;
    assign if_fp.a_regsel = if_rr.a_regsel;
    assign if_fp.b_regsel = if_rr.b_regsel;
    assign if_fp.a_data   = if_rr.a_data;
    assign if_fp.b_data   = if_rr.b_data;

    rf_wr_arb #(.RR_EN(1'b1)) u_rr (.clk(clk), .rst(rst), .bus(if_rr));
    rf_wr_arb #(.RR_EN(1'b0)) u_fp (.clk(clk), .rst(rst), .bus(if_fp));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_rr.stall    = 1'b0;
        if_rr.a_req    = 1'b0;
        if_rr.b_req    = 1'b0;
        if_rr.a_regsel = 3'd0;
        if_rr.b_regsel = 3'd0;
        if_rr.a_data   = 16'h0000;
        if_rr.b_data   = 16'h0000;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0;
        idle_inputs();
        #2;
        rst = 1'b1;
    endtask

    task automatic drive_tie();
        if_rr.a_req    = 1'b1;
        if_rr.b_req    = 1'b1;
        if_rr.a_regsel = 3'd1;
        if_rr.a_data   = 16'hAAAA;
        if_rr.b_regsel = 3'd2;
        if_rr.b_data   = 16'hBBBB;
    endtask

    initial begin
        clk   = 1'b0;
        rst   = 1'b0;
        n_cmp = 0;
        n_err = 0;
        idle_inputs();
        if_rr.a_req = 1'b1;
        if_rr.b_req = 1'b1;

        // reset state, with requests asserted to show grants are gated
        #1;
        chk("rst_write", {31'd0, if_rr.write}, 32'd0);
        chk("rst_sel", {29'd0, if_rr.writeregsel}, 32'd0);
        chk("rst_data", {16'd0, if_rr.writedata}, 32'd0);
        chk("rst_pend", {24'd0, if_rr.pend}, 32'd0);
        chk("rst_a_gnt", {31'd0, if_rr.a_gnt}, 32'd0);
        chk("rst_b_gnt", {31'd0, if_rr.b_gnt}, 32'd0);
        tick();
        tick();
        chk("rst_cnt_held", {24'd0, if_rr.conflict_cnt}, 32'd0);
        chk("rst_write_held", {31'd0, if_rr.write}, 32'd0);
        rst = 1'b1;
        idle_inputs();

        // single request from A
        do_reset();
        tick();
        if_rr.a_req    = 1'b1;
        if_rr.a_regsel = 3'd3;
        if_rr.a_data   = 16'hBEEF;
        #1;
        chk("single_a_gnt", {31'd0, if_rr.a_gnt}, 32'd1);
        chk("single_b_gnt", {31'd0, if_rr.b_gnt}, 32'd0);
        tick();
        if_rr.a_req = 1'b0;
        chk("single_write", {31'd0, if_rr.write}, 32'd1);
        chk("single_sel", {29'd0, if_rr.writeregsel}, 32'd3);
        chk("single_data", {16'd0, if_rr.writedata}, 32'h0000BEEF);
        chk("single_pend", {24'd0, if_rr.pend}, 32'd0);
        tick();
        chk("single_write_off", {31'd0, if_rr.write}, 32'd0);
        chk("single_sel_hold", {29'd0, if_rr.writeregsel}, 32'd3);
        chk("single_data_hold", {16'd0, if_rr.writedata}, 32'h0000BEEF);

        // continuous tie: round-robin alternates from A, fixed priority always A
        do_reset();
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k > 0) begin
                chk("rr_write", {31'd0, if_rr.write}, 32'd1);
                chk("rr_sel", {29'd0, if_rr.writeregsel}, ((k - 1) % 2 == 0) ? 32'd1 : 32'd2);
                chk("rr_data", {16'd0, if_rr.writedata}, ((k - 1) % 2 == 0) ? 32'h0000AAAA : 32'h0000BBBB);
                chk("rr_pend", {24'd0, if_rr.pend}, ((k - 1) % 2 == 0) ? 32'h04 : 32'h02);
                chk("fp_write", {31'd0, if_fp.write}, 32'd1);
                chk("fp_sel", {29'd0, if_fp.writeregsel}, 32'd1);
                chk("fp_pend", {24'd0, if_fp.pend}, 32'h04);
            end
            if (k < 6) begin
                drive_tie();
                #1;
                chk("rr_a_gnt", {31'd0, if_rr.a_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
                chk("rr_b_gnt", {31'd0, if_rr.b_gnt}, (k % 2 == 0) ? 32'd0 : 32'd1);
                chk("fp_a_gnt", {31'd0, if_fp.a_gnt}, 32'd1);
                chk("fp_b_gnt", {31'd0, if_fp.b_gnt}, 32'd0);
            end else begin
                idle_inputs();
                chk("rr_tie_cnt", {24'd0, if_rr.conflict_cnt}, 32'd6);
                chk("fp_tie_cnt", {24'd0, if_fp.conflict_cnt}, 32'd6);
            end
        end

        // both requesters target the same register: two writes, later one survives
        do_reset();
        tick();
        if_rr.a_req    = 1'b1;
        if_rr.b_req    = 1'b1;
        if_rr.a_regsel = 3'd5;
        if_rr.b_regsel = 3'd5;
        if_rr.a_data   = 16'h1111;
        if_rr.b_data   = 16'h2222;
        #1;
        chk("same_a_gnt", {31'd0, if_rr.a_gnt}, 32'd1);
        tick();
        chk("same_w1", {31'd0, if_rr.write}, 32'd1);
        chk("same_sel1", {29'd0, if_rr.writeregsel}, 32'd5);
        chk("same_data1", {16'd0, if_rr.writedata}, 32'h00001111);
        chk("same_pend1", {24'd0, if_rr.pend}, 32'h20);
        if_rr.a_req = 1'b0;
        #1;
        chk("same_b_gnt", {31'd0, if_rr.b_gnt}, 32'd1);
        tick();
        idle_inputs();
        chk("same_w2", {31'd0, if_rr.write}, 32'd1);
        chk("same_sel2", {29'd0, if_rr.writeregsel}, 32'd5);
        chk("same_data2", {16'd0, if_rr.writedata}, 32'h00002222);
        chk("same_pend2", {24'd0, if_rr.pend}, 32'd0);

        // stall for two cycles with both requesting
        do_reset();
        tick();
        drive_tie();
        if_rr.stall = 1'b1;
        #1;
        chk("stall_a_gnt", {31'd0, if_rr.a_gnt}, 32'd0);
        chk("stall_b_gnt", {31'd0, if_rr.b_gnt}, 32'd0);
        tick();
        chk("stall_write1", {31'd0, if_rr.write}, 32'd0);
        chk("stall_pend1", {24'd0, if_rr.pend}, 32'h06);
        chk("stall_a_gnt2", {31'd0, if_rr.a_gnt}, 32'd0);
        tick();
        chk("stall_write2", {31'd0, if_rr.write}, 32'd0);
        chk("stall_cnt", {24'd0, if_rr.conflict_cnt}, 32'd2);
        if_rr.stall = 1'b0;
        #1;
        chk("unstall_a_gnt", {31'd0, if_rr.a_gnt}, 32'd1);
        chk("unstall_b_gnt", {31'd0, if_rr.b_gnt}, 32'd0);
        tick();
        idle_inputs();
        chk("unstall_write", {31'd0, if_rr.write}, 32'd1);
        chk("unstall_sel", {29'd0, if_rr.writeregsel}, 32'd1);
        chk("unstall_cnt", {24'd0, if_rr.conflict_cnt}, 32'd3);

        // conflict counter saturation
        do_reset();
        tick();
        drive_tie();
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 100) chk("sat_cnt_100", {24'd0, if_rr.conflict_cnt}, 32'd100);
            if (i == 255) chk("sat_cnt_255", {24'd0, if_rr.conflict_cnt}, 32'd255);
            if (i == 300) chk("sat_cnt_300", {24'd0, if_rr.conflict_cnt}, 32'd255);
        end
        idle_inputs();

        // asynchronous reset while B holds a live grant
        do_reset();
        tick();
        drive_tie();
        tick();
        chk("arst_pre_write", {31'd0, if_rr.write}, 32'd1);
        chk("arst_pre_b_gnt", {31'd0, if_rr.b_gnt}, 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_write", {31'd0, if_rr.write}, 32'd0);
        chk("arst_sel", {29'd0, if_rr.writeregsel}, 32'd0);
        chk("arst_data", {16'd0, if_rr.writedata}, 32'd0);
        chk("arst_pend", {24'd0, if_rr.pend}, 32'd0);
        chk("arst_cnt", {24'd0, if_rr.conflict_cnt}, 32'd0);
        chk("arst_a_gnt", {31'd0, if_rr.a_gnt}, 32'd0);
        chk("arst_b_gnt", {31'd0, if_rr.b_gnt}, 32'd0);
        tick();
        chk("arst_no_write", {31'd0, if_rr.write}, 32'd0);
        rst = 1'b1;
        #1;
        chk("arst_resume_a_gnt", {31'd0, if_rr.a_gnt}, 32'd1);
        chk("arst_resume_b_gnt", {31'd0, if_rr.b_gnt}, 32'd0);
        tick();
        idle_inputs();
        chk("arst_resume_write", {31'd0, if_rr.write}, 32'd1);
        chk("arst_resume_sel", {29'd0, if_rr.writeregsel}, 32'd1);
        chk("arst_resume_data", {16'd0, if_rr.writedata}, 32'h0000AAAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rf_wr_arb.md
RF_WR_ARB -- requirements
Module: rf_wr_arb

Interface
REQ-001 SHALL have parameter RR_EN, default 1: 1 = round-robin arbitration, 0 = fixed priority (A over B).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port stall, input, 1 bit: when high, no grant is issued.
REQ-005 SHALL have ports a_req, input, 1 bit, and b_req, input, 1 bit: write requests from requester A (ALU writeback) and requester B (load writeback).
REQ-006 SHALL have ports a_regsel, input, 3 bits, and b_regsel, input, 3 bits: destination register of each requester.
REQ-007 SHALL have ports a_data, input, 16 bits, and b_data, input, 16 bits: write data of each requester.
REQ-008 SHALL have ports a_gnt, output, 1 bit, and b_gnt, output, 1 bit: combinational grants.
REQ-009 SHALL have port write, output, 1 bit: register-file write enable, registered.
REQ-010 SHALL have port writeregsel, output, 3 bits: register-file write select, registered.
REQ-011 SHALL have port writedata, output, 16 bits: register-file write data, registered.
REQ-012 SHALL have port pend, output, 8 bits: one-hot pending-destination vector, registered.
REQ-013 SHALL have port conflict_cnt, output, 8 bits: saturating count of cycles in which both requesters were asserted.

Function
REQ-014 SHALL keep a 1-bit last-grant pointer lg, where 0 = A was last granted and 1 = B was last granted.
REQ-015 SHALL, with stall=0 and exactly one request asserted, grant that requester in the same cycle.
REQ-016 SHALL, with stall=0, both requests asserted and RR_EN=1, grant B if lg=0 and A if lg=1.
REQ-017 SHALL, with stall=0, both requests asserted and RR_EN=0, always grant A.
REQ-018 SHALL assert at most one of a_gnt and b_gnt in any cycle, and never a grant while stall=1 or while the corresponding request is low.
REQ-019 SHALL update lg to the granted requester on each clock edge where a grant occurs; lg SHALL hold otherwise.
REQ-020 SHALL, on a grant in cycle N, drive write=1 and the granted regsel and data on writeregsel and writedata in cycle N+1 (latency 1).
REQ-021 SHALL drive write=0 in any cycle following a no-grant cycle, with writeregsel and writedata holding their previous values.
REQ-022 SHALL require an ungranted requester to hold its req, regsel and data stable; a request that is dropped before being granted is discarded with no write.
REQ-023 SHALL set pend bit r in cycle N+1 when requester A or B is waiting ungranted in cycle N with regsel=r; all other pend bits SHALL be 0.
REQ-024 SHALL produce two writes in consecutive cycles, in grant order, when both requesters target the same register, so that the later-granted data is what finally remains in that register.
REQ-025 SHALL increment conflict_cnt on each edge where a_req=b_req=1, regardless of stall, saturating at 255 with no wrap-around.
REQ-026 SHALL sustain back-to-back grants every cycle with no bubble inserted by the block itself.

Reset
REQ-027 SHALL, while rst=0, immediately force write=0, writeregsel=0, writedata=0, pend=0, conflict_cnt=0 and lg=1, so that A wins the first tie.
REQ-028 SHALL, on rst asserted mid-operation, lose any grant issued in the same cycle with no write produced; a_gnt and b_gnt SHALL be 0 while rst=0.
REQ-029 SHALL resume normal arbitration on the first rising edge after rst deasserts.

Verification
REQ-030 Single request: reset, then a_req=1, a_regsel=3, a_data=16'hBEEF for one cycle -> a_gnt=1 that cycle; next cycle write=1, writeregsel=3, writedata=16'hBEEF; the cycle after, write=0.
REQ-031 Tie, round-robin: A and B requesting continuously with RR_EN=1 -> grants alternate A, B, A, B starting with A; write=1 every cycle from the second cycle on.
REQ-032 Fixed priority: RR_EN=0, both requesting for 3 cycles -> a_gnt=1 all 3 cycles, b_gnt=0, pend shows b_regsel's bit from the second cycle on.
REQ-033 Stall: both requesting, stall=1 for 2 cycles -> no grants, write=0, conflict_cnt increments by 2; on stall release, A is granted first.
REQ-034 Saturation: both requesting for 300 cycles -> conflict_cnt reaches 255 and stays at 255.
REQ-035 Async reset mid-burst: drive rst=0 between clock edges during alternating grants -> all outputs clear immediately; after release, a tie grants A first.
